i2c_target: RTL

//  I2C target (slave) for the board-level I2C bus: responds at a fixed 7-bit address,

---
 rtl/i2c_target_if.sv | 11 +
 rtl/i2c_target.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_if.sv
// Register-port bundle between the I2C target and the register space it exposes.
interface i2c_target_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_rdata;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       busy;

  modport slave  (output reg_addr, reg_wdata, reg_we, busy, input  reg_rdata);
  modport master (input  reg_addr, reg_wdata, reg_we, busy, output reg_rdata);
endinterface

// File: rtl/i2c_target.sv
// I2C target at a fixed 7-bit address: pointer byte then sequential byte writes,
// or sequential reads from the pointer. Oversampled bus, open-drain SDA, no stretching.
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h48,
  parameter int unsigned CLK_HZ      = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_pin,
  inout  wire         sda_pin,
  i2c_target_if.slave regs
);

  if (CLK_HZ < 2_000_000) begin : g_clk_check
    $error("i2c_target: CLK_HZ too low to oversample a 100 kHz SCL");
  end

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
  } state_t;

  // Stage p0/p1: two-flop synchronizers; p2: delayed copy for edge detection
  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_pin; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= sda_pin; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 &  scl_p2;
  assign start_det =  scl_p1 &  scl_p2 & ~sda_p1 &  sda_p2;
  assign stop_det  =  scl_p1 &  scl_p2 &  sda_p1 & ~sda_p2;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, shift_in;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
  logic       we_q, we_d, busy_q, busy_d, sda_low_q, sda_low_d;
  logic       rw_q, rw_d, nack_q, nack_d, load_q, load_d;

  assign shift_in = {shift_q[6:0], sda_p1};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    busy_d    = busy_q;
    sda_low_d = sda_low_q;
    rw_d      = rw_q;
    nack_d    = nack_q;
    load_d    = 1'b0;
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b1;
      sda_low_d = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WR: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                rw_d    = sda_p1;
                state_d = (shift_in[7:1] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
              end else if (state_q == PTR) begin
                addr_d  = shift_in;
                state_d = PTR_ACK;
              end else begin
                wdata_d = shift_in;
                we_d    = 1'b1;
                state_d = WR_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          // sda_low_q doubles as the phase flag: first fall drives, second fall ends the slot
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = WR;
              if (state_q == WR_ACK) addr_d = addr_q + 8'd1;
              if (state_q == ADDR_ACK) begin
                if (rw_q) begin
                  shift_d   = regs.reg_rdata;
                  sda_low_d = ~regs.reg_rdata[7];
                  state_d   = RD;
                end else begin
                  state_d   = PTR;
                end
              end
            end
          end
        end
        RD: begin
          if (load_q) begin
            // pointer advanced last cycle; reg_rdata now reflects the new address
            shift_d   = regs.reg_rdata;
            sda_low_d = ~regs.reg_rdata[7];
          end else if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_low_d = 1'b0;
              state_d   = RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], shift_q[7]};
              sda_low_d = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            nack_d = sda_p1;
          end else if (scl_fall) begin
            addr_d    = addr_q + 8'd1;
            bit_cnt_d = 3'd0;
            if (nack_q) begin
              state_d = IGNORE;
            end else begin
              state_d = RD;
              load_d  = 1'b1;
            end
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      addr_q    <= 8'd0;
      wdata_q   <= 8'd0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      sda_low_q <= 1'b0;
      rw_q      <= 1'b0;
      nack_q    <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      sda_low_q <= sda_low_d;
      rw_q      <= rw_d;
      nack_q    <= nack_d;
      load_q    <= load_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign sda_pin        = sda_low_q ? 1'b0 : 1'bz;
  assign regs.reg_addr  = addr_q;
  assign regs.reg_wdata = wdata_q;
  assign regs.reg_we    = we_q;
  assign regs.busy      = busy_q;

endmodule
